disp_layer_regctrl: RTL and testbench

DISP_LAYER_REGCTRL -- requirements
Module: disp_layer_regctrl

---
 rtl/disp_layer_regctrl.sv | 211 +++++++++++++++++++++
 tb/tb_disp_layer_regctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_layer_regctrl.sv
`default_nettype none
// ============================================================================
// Module  : disp_layer_regctrl
// Brief   : Display layer register block. Holds pending per-layer frame
//           addresses/enables, commits them to the active outputs on vsync,
//           tracks FIFO error flags, frame count and interrupt status.
// Revision: 1.0 - initial release
// ============================================================================
module disp_layer_regctrl #(
  parameter int NLAYER = 2,
  parameter int AW     = 29
) (
  input  logic                 ACLK,
  input  logic                 ARST,
  input  logic                 DSP_VSYNC_X,
  input  logic [15:0]          WRADDR,
  input  logic [3:0]           BYTEEN,
  input  logic                 WREN,
  input  logic [31:0]          WDATA,
  input  logic [15:0]          RDADDR,
  input  logic                 RDEN,
  output logic [31:0]          RDATA,
  output logic [NLAYER-1:0]    DISPON,
  output logic [NLAYER*AW-1:0] DISPADDR,
  output logic                 DSP_IRQ,
  input  logic [NLAYER-1:0]    BUF_UNDER,
  input  logic [NLAYER-1:0]    BUF_OVER
);

  // Word offsets (byte address >> 2) of the global registers
  localparam logic [9:0] c_off_status   = 10'h040;
  localparam logic [9:0] c_off_inten    = 10'h041;
  localparam logic [9:0] c_off_intstat  = 10'h042;
  localparam logic [9:0] c_off_framecnt = 10'h043;

  logic        w_wsel;
  logic        w_rsel;
  logic [9:0]  w_woff;
  logic [9:0]  w_roff;
  logic        w_wlayer;
  logic [31:0] w_bemask;
  logic        w_vev;
  logic        w_fifo_err;
  logic        w_lcfg_wr;
  logic [3:0]  w_lcfg_wr_vec;
  logic        w_wr_status;
  logic        w_wr_inten;
  logic        w_wr_intstat;
  logic [31:0] w_rd_data;
  logic        w_unused_bits;

  // Readback views padded to the full 4-layer map; absent layers read 0
  logic [31:0] w_rd_laddr [4];
  logic        w_rd_lctrl [4];
  logic [1:0]  w_rd_lfifo [4];

  logic        r_vs1;
  logic        r_vs2;
  logic        r_vs3;
  logic        r_vblank;
  logic        r_updpend;
  logic [1:0]  r_inten;
  logic [1:0]  r_intstat;
  logic [15:0] r_framecnt;
  logic [31:0] r_rdata;
  logic        r_irq;

  assign w_wsel    = WREN && (WRADDR[15:12] == 4'd0);
  assign w_rsel    = RDEN && (RDADDR[15:12] == 4'd0);
  assign w_woff    = WRADDR[11:2];
  assign w_roff    = RDADDR[11:2];
  assign w_wlayer  = (w_woff[9:4] == 6'd0);
  assign w_bemask  = {{8{BYTEEN[3]}}, {8{BYTEEN[2]}}, {8{BYTEEN[1]}}, {8{BYTEEN[0]}}};

  // Falling edge of the synchronised vsync; r_vs3 is the previous sample
  assign w_vev      = r_vs3 & ~r_vs2;
  assign w_fifo_err = (|BUF_UNDER) | (|BUF_OVER);
  assign w_lcfg_wr  = |w_lcfg_wr_vec;

  assign w_wr_status  = w_wsel && (w_woff == c_off_status)  && BYTEEN[0];
  assign w_wr_inten   = w_wsel && (w_woff == c_off_inten)   && BYTEEN[0];
  assign w_wr_intstat = w_wsel && (w_woff == c_off_intstat) && BYTEEN[0];

  // Address bits below word granularity and data bits above AW carry no state
  assign w_unused_bits = ^{WRADDR[1:0], RDADDR[1:0], WDATA, w_bemask};

  genvar n;
  generate
    for (n = 0; n < 4; n++) begin : g_lay
      if (n < NLAYER) begin : g_present
        logic [AW-1:0] r_laddr;
        logic [AW-1:0] r_dispaddr;
        logic          r_lctrl;
        logic          r_dispon;
        logic          r_under;
        logic          r_over;
        logic          w_sel_laddr;
        logic          w_sel_lctrl;
        logic          w_sel_lfifo;

        assign w_sel_laddr = w_wsel && w_wlayer && (w_woff[3:2] == 2'(n)) && (w_woff[1:0] == 2'd0);
        assign w_sel_lctrl = w_wsel && w_wlayer && (w_woff[3:2] == 2'(n)) && (w_woff[1:0] == 2'd1);
        assign w_sel_lfifo = w_wsel && w_wlayer && (w_woff[3:2] == 2'(n)) && (w_woff[1:0] == 2'd2)
                             && BYTEEN[0];

        // Pending config, vsync commit (uses pre-write values) and sticky FIFO flags
        always_ff @(posedge ACLK) begin
          if (ARST) begin
            r_laddr    <= '0;
            r_dispaddr <= '0;
            r_lctrl    <= 1'b0;
            r_dispon   <= 1'b0;
            r_under    <= 1'b0;
            r_over     <= 1'b0;
          end else begin
            if (w_sel_laddr)
              r_laddr <= (r_laddr & ~w_bemask[AW-1:0]) | (WDATA[AW-1:0] & w_bemask[AW-1:0]);
            if (w_sel_lctrl && BYTEEN[0])
              r_lctrl <= WDATA[0];
            if (w_vev && r_updpend) begin
              r_dispaddr <= r_laddr;
              r_dispon   <= r_lctrl;
            end
            r_under <= (r_under & ~(w_sel_lfifo & WDATA[0])) | BUF_UNDER[n];
            r_over  <= (r_over  & ~(w_sel_lfifo & WDATA[1])) | BUF_OVER[n];
          end
        end

        assign DISPON[n]             = r_dispon;
        assign DISPADDR[n*AW +: AW]  = r_dispaddr;
        assign w_rd_laddr[n]         = 32'(r_laddr);
        assign w_rd_lctrl[n]         = r_lctrl;
        assign w_rd_lfifo[n]         = {r_over, r_under};
        assign w_lcfg_wr_vec[n]      = w_sel_laddr | w_sel_lctrl;
      end else begin : g_absent
        assign w_rd_laddr[n]    = '0;
        assign w_rd_lctrl[n]    = 1'b0;
        assign w_rd_lfifo[n]    = 2'b00;
        assign w_lcfg_wr_vec[n] = 1'b0;
      end
    end
  endgenerate

  // Vsync synchroniser, global status/interrupt state, frame counter, IRQ and read data
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      r_vs1      <= 1'b1;
      r_vs2      <= 1'b1;
      r_vs3      <= 1'b1;
      r_vblank   <= 1'b0;
      r_updpend  <= 1'b0;
      r_inten    <= 2'b00;
      r_intstat  <= 2'b00;
      r_framecnt <= 16'd0;
      r_rdata    <= 32'd0;
      r_irq      <= 1'b0;
    end else begin
      r_vs1 <= DSP_VSYNC_X;
      r_vs2 <= r_vs1;
      r_vs3 <= r_vs2;

      r_vblank <= (r_vblank & ~(w_wr_status & WDATA[0])) | w_vev;

      // A new write after (or during) a commit keeps the update pending
      if (w_lcfg_wr)
        r_updpend <= 1'b1;
      else if (w_vev)
        r_updpend <= 1'b0;

      if (w_wr_inten)
        r_inten <= WDATA[1:0];

      r_intstat <= (r_intstat & ~(w_wr_intstat ? WDATA[1:0] : 2'b00))
                   | {w_fifo_err, w_vev};

      if (w_vev)
        r_framecnt <= r_framecnt + 16'd1;

      r_irq <= |(r_intstat & r_inten);

      if (w_rsel)
        r_rdata <= w_rd_data;
    end
  end

  // Read mux over the register map as it stands before any same-cycle write
  always_comb begin
    w_rd_data = '0;
    if (w_roff[9:4] == 6'd0) begin
      case (w_roff[1:0])
        2'd0:    w_rd_data = w_rd_laddr[w_roff[3:2]];
        2'd1:    w_rd_data = {31'd0, w_rd_lctrl[w_roff[3:2]]};
        2'd2:    w_rd_data = {30'd0, w_rd_lfifo[w_roff[3:2]]};
        default: w_rd_data = '0;
      endcase
    end else begin
      case (w_roff)
        c_off_status:   w_rd_data = {30'd0, r_updpend, r_vblank};
        c_off_inten:    w_rd_data = {30'd0, r_inten};
        c_off_intstat:  w_rd_data = {30'd0, r_intstat};
        c_off_framecnt: w_rd_data = {16'd0, r_framecnt};
        default:        w_rd_data = '0;
      endcase
    end
  end

  assign RDATA   = r_rdata;
  assign DSP_IRQ = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_disp_layer_regctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_disp_layer_regctrl
// Brief   : Directed bench for disp_layer_regctrl. Reads push their expected
//           data into a scoreboard queue; a monitor pops and compares when
//           RDATA becomes valid. Sideband outputs are checked directly.
// Revision: 1.0 - initial release
// ============================================================================
module tb_disp_layer_regctrl;

  localparam int NLAYER = 2;
  localparam int AW     = 29;

  logic                 ACLK        = 1'b0;
  logic                 ARST        = 1'b1;
  logic                 DSP_VSYNC_X = 1'b1;
  logic [15:0]          WRADDR      = '0;
  logic [3:0]           BYTEEN      = '0;
  logic                 WREN        = 1'b0;
  logic [31:0]          WDATA       = '0;
  logic [15:0]          RDADDR      = '0;
  logic                 RDEN        = 1'b0;
  logic [31:0]          RDATA;
  logic [NLAYER-1:0]    DISPON;
  logic [NLAYER*AW-1:0] DISPADDR;
  logic                 DSP_IRQ;
  logic [NLAYER-1:0]    BUF_UNDER   = '0;
  logic [NLAYER-1:0]    BUF_OVER    = '0;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_vs    = 0;
  logic [31:0] q_exp  [$];
  string       q_name [$];
  logic        r_rd_seen = 1'b0;

  disp_layer_regctrl #(.NLAYER(NLAYER), .AW(AW)) dut (
    .ACLK        (ACLK),
    .ARST        (ARST),
    .DSP_VSYNC_X (DSP_VSYNC_X),
    .WRADDR      (WRADDR),
    .BYTEEN      (BYTEEN),
    .WREN        (WREN),
    .WDATA       (WDATA),
    .RDADDR      (RDADDR),
    .RDEN        (RDEN),
    .RDATA       (RDATA),
    .DISPON      (DISPON),
    .DISPADDR    (DISPADDR),
    .DSP_IRQ     (DSP_IRQ),
    .BUF_UNDER   (BUF_UNDER),
    .BUF_OVER    (BUF_OVER)
  );

  always #5 ACLK = ~ACLK;

  // Remember that a selected read was sampled so RDATA is valid this cycle
  always @(posedge ACLK) r_rd_seen <= RDEN && (RDADDR[15:12] == 4'h0) && !ARST;

  // Scoreboard monitor: compare RDATA against the oldest expected read
  always @(negedge ACLK) begin
    if (r_rd_seen) begin
      n_tests++;
      if (q_exp.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got %h, required no read", RDATA);
      end else begin
        logic [31:0] e;
        string       nm;
        e  = q_exp.pop_front();
        nm = q_name.pop_front();
        if (RDATA !== e) begin
          n_fail++;
          $display("FAIL %s: got %h, required %h", nm, RDATA, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    WRADDR = a; WDATA = d; BYTEEN = be; WREN = 1'b1;
    tick(1);
    WREN = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] exp, input string nm);
    RDADDR = a; RDEN = 1'b1;
    q_exp.push_back(exp);
    q_name.push_back(nm);
    tick(1);
    RDEN = 1'b0;
  endtask

  // Minimal vsync low pulse; the resulting event lands a couple of edges later
  task automatic vs_pulse();
    DSP_VSYNC_X = 1'b0;
    tick(1);
    DSP_VSYNC_X = 1'b1;
    tick(1);
  endtask

  // Vsync edge whose event cycle coincides exactly with a register write
  task automatic vs_edge_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    DSP_VSYNC_X = 1'b0;
    tick(2);
    WRADDR = a; WDATA = d; BYTEEN = be; WREN = 1'b1;
    tick(1);
    WREN = 1'b0;
    DSP_VSYNC_X = 1'b1;
    tick(3);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(3);
    ARST = 1'b0;

    // Reset state
    chk("rst_dispon",   64'(DISPON),   64'h0);
    chk("rst_dispaddr", 64'(DISPADDR), 64'h0);
    chk("rst_irq",      64'(DSP_IRQ),  64'h0);
    chk("rst_rdata",    64'(RDATA),    64'h0);
    rd(16'h0100, 32'h0, "rst_status");
    rd(16'h010C, 32'h0, "rst_framecnt");

    // Pending config does not reach the outputs without vsync
    wr(16'h0000, 32'h0123_4560, 4'hF);
    wr(16'h0004, 32'h1, 4'hF);
    tick(4);
    chk("nocommit_dispaddr", 64'(DISPADDR), 64'h0);
    chk("nocommit_dispon",   64'(DISPON),   64'h0);
    rd(16'h0100, 32'h2, "status_updpend");
    rd(16'h0000, 32'h0123_4560, "laddr0_rd");

    vs_pulse(); n_vs++;
    tick(3);
    chk("commit_dispaddr0", 64'(DISPADDR[28:0]), 64'h0123_4560);
    chk("commit_dispon",    64'(DISPON),         64'h1);
    rd(16'h0100, 32'h1, "status_after_vs");
    rd(16'h010C, 32'h1, "framecnt_1");

    // Byte-lane writes and bits above AW
    wr(16'h0010, 32'h0, 4'hF);
    wr(16'h0010, 32'hFFFF_FFFF, 4'b0010);
    rd(16'h0010, 32'h0000_FF00, "laddr1_lane1");
    wr(16'h0010, 32'hFFFF_FFFF, 4'hF);
    rd(16'h0010, 32'h1FFF_FFFF, "laddr1_aw_mask");
    wr(16'h0014, 32'h1, 4'hF);

    // Vsync interrupt, W1C clear
    wr(16'h0108, 32'h3, 4'hF);
    wr(16'h0100, 32'h1, 4'hF);
    wr(16'h0104, 32'h1, 4'hF);
    tick(2);
    chk("irq_idle", 64'(DSP_IRQ), 64'h0);
    vs_pulse(); n_vs++;
    tick(3);
    chk("irq_vsync",        64'(DSP_IRQ),         64'h1);
    chk("commit_dispaddr1", 64'(DISPADDR[57:29]), 64'h1FFF_FFFF);
    chk("commit_dispon_11", 64'(DISPON),          64'h3);
    wr(16'h0108, 32'h1, 4'hF);
    tick(1);
    chk("irq_cleared", 64'(DSP_IRQ), 64'h0);
    rd(16'h0108, 32'h0, "intstat_cleared");

    // W1C clear coinciding with the vsync event: set wins
    vs_edge_wr(16'h0108, 32'h1, 4'hF); n_vs++;
    rd(16'h0108, 32'h1, "intstat_set_wins");
    rd(16'h0108, 32'h1, "intstat_read_noclr");
    chk("irq_set_wins", 64'(DSP_IRQ), 64'h1);

    // Config write coinciding with commit: commit uses old pending value
    wr(16'h0000, 32'h00AA_AA00, 4'hF);
    vs_edge_wr(16'h0000, 32'h00BB_BB00, 4'hF); n_vs++;
    chk("coincide_dispaddr0", 64'(DISPADDR[28:0]), 64'h00AA_AA00);
    rd(16'h0100, 32'h3, "coincide_status");
    rd(16'h0000, 32'h00BB_BB00, "coincide_laddr0");

    // FIFO overflow flag and interrupt
    wr(16'h0108, 32'h3, 4'hF);
    wr(16'h0104, 32'h2, 4'hF);
    tick(2);
    chk("irq_pre_fifo", 64'(DSP_IRQ), 64'h0);
    BUF_OVER = 2'b10;
    tick(1);
    BUF_OVER = 2'b00;
    tick(2);
    chk("irq_fifo", 64'(DSP_IRQ), 64'h1);
    rd(16'h0018, 32'h2, "lfifo1_over");
    rd(16'h0008, 32'h0, "lfifo0_clean");
    rd(16'h0108, 32'h2, "intstat_fifo");
    wr(16'h0018, 32'h2, 4'hF);
    rd(16'h0018, 32'h0, "lfifo1_w1c");
    BUF_UNDER = 2'b01;
    wr(16'h0008, 32'h1, 4'hF);
    BUF_UNDER = 2'b00;
    rd(16'h0008, 32'h1, "lfifo0_set_wins");

    // Byte enable 0 gates non-address registers
    wr(16'h0104, 32'h0, 4'b1110);
    rd(16'h0104, 32'h2, "inten_be0_gate");

    // Absent layers and unmapped offsets
    wr(16'h0020, 32'hFFFF_FFFF, 4'hF);
    rd(16'h0020, 32'h0, "layer2_rd");
    rd(16'h0030, 32'h0, "layer3_rd");
    rd(16'h000C, 32'h0, "unmapped_0c");
    rd(16'h0110, 32'h0, "unmapped_110");

    // RDATA holds when a read is not selected
    rd(16'h0104, 32'h2, "inten_rd");
    RDADDR = 16'h1104; RDEN = 1'b1;
    tick(1);
    RDEN = 1'b0;
    tick(1);
    chk("rdata_hold", 64'(RDATA), 64'h2);

    // Frame counter wraps
    while (n_vs < 65535) begin
      vs_pulse();
      n_vs++;
    end
    tick(4);
    rd(16'h010C, 32'h0000_FFFF, "framecnt_ffff");
    vs_pulse(); n_vs++;
    tick(3);
    rd(16'h010C, 32'h0000_0000, "framecnt_wrap");

    // Reset mid-frame discards the pending commit
    wr(16'h0000, 32'h0000_1230, 4'hF);
    tick(2);
    ARST = 1'b1;
    tick(2);
    ARST = 1'b0;
    chk("mrst_dispon",   64'(DISPON),   64'h0);
    chk("mrst_dispaddr", 64'(DISPADDR), 64'h0);
    chk("mrst_irq",      64'(DSP_IRQ),  64'h0);
    chk("mrst_rdata",    64'(RDATA),    64'h0);
    tick(2);
    rd(16'h010C, 32'h0, "mrst_no_vev");
    vs_pulse();
    tick(3);
    chk("mrst_vs_dispon",   64'(DISPON),   64'h0);
    chk("mrst_vs_dispaddr", 64'(DISPADDR), 64'h0);
    rd(16'h0100, 32'h1, "mrst_status");
    rd(16'h010C, 32'h1, "mrst_framecnt");

    tick(3);
    chk("scoreboard_drained", 64'(q_exp.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
